// File: rtl/burst_addr_gen.sv
// Burst address generator: turns one request into BURST_LEN strided SRAM
// accesses, streaming write beats in and returning read beats one cycle later.
module burst_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 15,
  parameter int unsigned STRIDE_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(STRIDE_LEN);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    READ_LAST
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_beat;
  logic                  rd_beat;
  logic                  last;

  // Access strobes are decoded from the registered state so that a write beat
  // and the done pulse land in the same cycle wdata_valid is seen.
  always_comb begin
    wr_beat     = (state == WRITE) && wdata_valid;
    rd_beat     = (state == READ);
    last        = (cnt == LAST_BEAT);
    req_ready   = (state == IDLE);
    busy        = (state != IDLE);
    wdata_ready = (state == WRITE);
    sram_en     = wr_beat || rd_beat;
    sram_we     = wr_beat;
    sram_addr   = addr;
    sram_wdata  = wr_beat ? wdata : '0;
    done        = (wr_beat && last) || (state == READ_LAST);
    rdata       = rdata_valid ? sram_rdata : '0;
  end

  // State, address, beat counter and the one-cycle read-return flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= sram_en && !sram_we;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr  <= req_addr;
            cnt   <= '0;
            state <= req_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wdata_valid) begin
            addr <= addr + STRIDE;
            if (last) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        READ: begin
          addr <= addr + STRIDE;
          if (last) begin
            cnt   <= '0;
            state <= READ_LAST;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        READ_LAST: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
